dff_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit storage register, built from falling-edge D flip-flops with true/complement outputs, among N_REQ requesters. A req/gnt handshake decides which requester writes the register and holds ownership for a fixed window. The block sits between several producer blocks and the shared storage, and is the only writer of that storage.

---
 rtl/dff_arb_pkg.sv | 17 +
 rtl/dff_bank.sv | 27 ++
 rtl/dff_reg_arbiter.sv | 127 ++++++++++++
 tb/tb_dff_reg_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin storage arbiter: FSM state encoding
// and the owner index width helper.
package dff_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // A single requester still needs one bit to name its owner index.
   function automatic int owner_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dff_bank.sv
// WIDTH-bit falling-edge storage register with write enable, asynchronous
// active-low clear and complementary outputs.
module dff_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq
);

   logic [WIDTH-1:0] data_q;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (we) begin
         data_q <= d;
      end
   end

   assign q  = data_q;
   assign nq = ~data_q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin req/gnt arbiter granting one requester at a time a single write
// into the shared falling-edge storage bank, followed by a fixed hold window.
module dff_reg_arbiter
   import dff_arb_pkg::*;
#(
   parameter  int N_REQ       = 4,
   parameter  int WIDTH       = 8,
   parameter  int HOLD_CYCLES = 2,
   localparam int OW          = owner_w(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [OW-1:0]          owner,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       nq
);

   localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

   state_t           state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic [OW-1:0]    cand_idx [N_REQ];
   logic             win_valid;
   logic [OW-1:0]    win_idx;
   logic             we;

   // Candidate gi is the requester gi+1 places after ptr, wrapped modulo N_REQ.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [OW:0] sum;
      assign sum          = {1'b0, ptr_q} + (OW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (OW+1)'(N_REQ)) ? OW'(sum - (OW+1)'(N_REQ))
                                                    : sum[OW-1:0];
   end

   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[cand_idx[k]]) begin
            win_valid = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               owner_d          = win_idx;
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
               state_d          = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!req[owner_q]) begin
               gnt_d   = '0;
               ptr_d   = owner_q;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            cnt_d   = CW'(HOLD_CYCLES - 1);
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               gnt_d   = '0;
               ptr_d   = owner_q;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= OW'(N_REQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end

   assign we    = (state_q == ST_WRITE);
   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_HOLD) && (cnt_q == '0);

   dff_bank #(.WIDTH(WIDTH)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .d     (wdata[owner_q*WIDTH +: WIDTH]),
      .q     (q),
      .nq    (nq)
   );

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scenario bench for dff_reg_arbiter; a negedge monitor pops expected writes
// from the scoreboard whenever done pulses.
module tb_dff_reg_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int HC = 2;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic [1:0]     owner;
   logic           busy;
   logic           done;
   logic [W-1:0]   q;
   logic [W-1:0]   nq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int           own;
      logic [W-1:0] data;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   dff_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(HC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .owner (owner),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .nq    (nq)
   );

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_done owner=%0d q=%h", owner, q);
         end else begin
            e = sb.pop_front();
            if (owner !== 2'(e.own) || q !== e.data || nq !== ~e.data ||
                gnt !== (4'b0001 << e.own)) begin
               bad++;
               $display("FAIL sb_write got owner=%0d q=%h nq=%h gnt=%b exp owner=%0d q=%h",
                        owner, q, nq, gnt, e.own, e.data);
            end else begin
               $display("txn owner=%0d q=%h nq=%h", owner, q, nq);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req   = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL %s_timeout done=%b", tag, done);
      end
   endtask

   task automatic test_reset;
      #1;
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || owner !== 2'd0 ||
          q !== 8'h00 || nq !== 8'hFF) begin
         bad++;
         $display("FAIL reset_state gnt=%b busy=%b done=%b owner=%0d q=%h nq=%h exp 0000/0/0/0/00/ff",
                  gnt, busy, done, owner, q, nq);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      do_reset();
      wdata[0 +: W] = 8'hA5;
      req = 4'b0001;
      sb.push_back('{0, 8'hA5});
      tick();
      total++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || q !== 8'h00) begin
         bad++;
         $display("FAIL single_grant gnt=%b busy=%b q=%h exp 0001/1/00", gnt, busy, q);
      end
      tick();
      total++;
      if (q !== 8'h00) begin
         bad++;
         $display("FAIL single_prewrite q=%h exp 00", q);
      end
      @(negedge clk);
      #1;
      total++;
      if (q !== 8'hA5 || nq !== 8'h5A) begin
         bad++;
         $display("FAIL single_write q=%h nq=%h exp a5/5a", q, nq);
      end
      tick();
      total++;
      if (done !== 1'b0 || gnt !== 4'b0001) begin
         bad++;
         $display("FAIL single_hold done=%b gnt=%b exp 0/0001", done, gnt);
      end
      tick();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL single_done done=%b exp 1", done);
      end
      req = '0;
      tick();
      total++;
      if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 1'b0) begin
         bad++;
         $display("FAIL single_idle busy=%b gnt=%b done=%b exp 0/0000/0", busy, gnt, done);
      end
   endtask

   task automatic test_round_robin;
      int order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
      for (int i = 0; i < 5; i++) sb.push_back('{order[i], 8'h10 + 8'(order[i])});
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         total++;
         if (gnt !== (4'b0001 << order[g])) begin
            bad++;
            $display("FAIL rr_grant%0d gnt=%b exp owner %0d", g, gnt, order[g]);
         end
         wait_done("rr");
         if (g == 4) req = '0;
         tick();
         total++;
         if (busy !== 1'b0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL rr_gap%0d busy=%b gnt=%b exp 0/0000", g, busy, gnt);
         end
      end
   endtask

   task automatic test_abort;
      do_reset();
      wdata[0 +: W] = 8'h77;
      wdata[W +: W] = 8'h99;
      req = 4'b0011;
      tick();
      total++;
      if (gnt !== 4'b0001 || owner !== 2'd0) begin
         bad++;
         $display("FAIL abort_grant gnt=%b owner=%0d exp 0001/0", gnt, owner);
      end
      req = 4'b0010;
      tick();
      total++;
      if (busy !== 1'b0 || gnt !== 4'b0000) begin
         bad++;
         $display("FAIL abort_idle busy=%b gnt=%b exp 0/0000", busy, gnt);
      end
      @(negedge clk);
      #1;
      total++;
      if (q !== 8'h00) begin
         bad++;
         $display("FAIL abort_nowrite q=%h exp 00", q);
      end
      req = 4'b0011;
      sb.push_back('{1, 8'h99});
      tick();
      total++;
      if (gnt !== 4'b0010 || owner !== 2'd1) begin
         bad++;
         $display("FAIL abort_regrant gnt=%b owner=%0d exp 0010/1", gnt, owner);
      end
      wait_done("abort");
      req = '0;
      tick();
   endtask

   task automatic test_late;
      do_reset();
      wdata[0 +: W]   = 8'h21;
      wdata[2*W +: W] = 8'h42;
      req = 4'b0001;
      sb.push_back('{0, 8'h21});
      sb.push_back('{2, 8'h42});
      tick();
      tick();
      tick();
      req = 4'b0101;
      tick();
      total++;
      if (gnt !== 4'b0001 || done !== 1'b1) begin
         bad++;
         $display("FAIL late_hold gnt=%b done=%b exp 0001/1", gnt, done);
      end
      req = 4'b0100;
      tick();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL late_idle gnt=%b busy=%b exp 0000/0", gnt, busy);
      end
      tick();
      total++;
      if (gnt !== 4'b0100) begin
         bad++;
         $display("FAIL late_grant gnt=%b exp 0100", gnt);
      end
      wait_done("late");
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid_hold;
      do_reset();
      wdata[0 +: W]   = 8'h3C;
      wdata[3*W +: W] = 8'hC3;
      req = 4'b0001;
      tick();
      tick();
      tick();
      total++;
      if (q !== 8'h3C || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_prewrite q=%h busy=%b exp 3c/1", q, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (q !== 8'h00 || nq !== 8'hFF || gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rst_async q=%h nq=%h gnt=%b busy=%b done=%b exp 00/ff/0000/0/0",
                  q, nq, gnt, busy, done);
      end
      req = 4'b1000;
      tick();
      rst_n = 1'b1;
      sb.push_back('{3, 8'hC3});
      tick();
      total++;
      if (gnt !== 4'b1000 || owner !== 2'd3) begin
         bad++;
         $display("FAIL rst_owner3 gnt=%b owner=%0d exp 1000/3", gnt, owner);
      end
      wait_done("rst");
      req = '0;
      tick();
      do_reset();
      req = 4'b1001;
      tick();
      total++;
      if (gnt !== 4'b0001 || owner !== 2'd0) begin
         bad++;
         $display("FAIL rst_owner0 gnt=%b owner=%0d exp 0001/0", gnt, owner);
      end
      req = '0;
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_abort busy=%b exp 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_late();
      test_reset_mid_hold();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover size=%0d exp 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
